// File: rtl/jk_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jk_pkg : shared mode encodings for the JK register bank
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
package jk_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_JK = 2'b00;
  localparam logic [MODE_W-1:0] MODE_UP = 2'b01;
  localparam logic [MODE_W-1:0] MODE_DN = 2'b10;
  localparam logic [MODE_W-1:0] MODE_LD = 2'b11;

endpackage : jk_pkg
`default_nettype wire

// File: rtl/jk_cell.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jk_cell : single JK flip-flop with clock enable and synchronous load
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic en,
  input  logic j,
  input  logic k,
  input  logic ld,
  input  logic d,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = d;
    end else begin
      case ({j, k})
        2'b00:   q_d = q_q;
        2'b01:   q_d = 1'b0;
        2'b10:   q_d = 1'b1;
        default: q_d = ~q_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= rst_val;
    end else if (en) begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : jk_cell
`default_nettype wire

// File: rtl/jk_reg_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jk_reg_bank : WIDTH-bit JK register bank with load and up/down counting
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module jk_reg_bank
  import jk_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  j,
  input  logic [WIDTH-1:0]  k,
  input  logic [WIDTH-1:0]  d,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  qn,
  output logic              wrap
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_carry;
  logic [WIDTH-1:0] w_borrow;
  logic [WIDTH-1:0] w_j_sel;
  logic [WIDTH-1:0] w_k_sel;
  logic             w_ld;
  logic             wrap_q;
  logic             wrap_d;

  // Bit i toggles when every lower bit is 1 (up) or 0 (down).
  assign w_carry[0]  = 1'b1;
  assign w_borrow[0] = 1'b1;

  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_chain
      assign w_carry[gi]  = &w_q[gi-1:0];
      assign w_borrow[gi] = ~|w_q[gi-1:0];
    end
  endgenerate

  always_comb begin
    w_j_sel = j;
    w_k_sel = k;
    w_ld    = 1'b0;
    wrap_d  = 1'b0;
    case (mode)
      MODE_UP: begin
        w_j_sel = w_carry;
        w_k_sel = w_carry;
        wrap_d  = &w_q;
      end
      MODE_DN: begin
        w_j_sel = w_borrow;
        w_k_sel = w_borrow;
        wrap_d  = ~|w_q;
      end
      MODE_LD: begin
        w_ld = 1'b1;
      end
      default: ;
    endcase
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      jk_cell u_cell (
        .clk     (clk),
        .rst     (rst),
        .rst_val (RESET_VAL[gi]),
        .en      (en),
        .j       (w_j_sel[gi]),
        .k       (w_k_sel[gi]),
        .ld      (w_ld),
        .d       (d[gi]),
        .q       (w_q[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else if (en) begin
      wrap_q <= wrap_d;
    end
  end

  assign q    = w_q;
  assign qn   = ~w_q;
  assign wrap = wrap_q;

endmodule : jk_reg_bank
`default_nettype wire
